// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared types and active-low segment patterns for the
//                common-anode 6-digit scan driver. Bit order {g,f,e,d,c,b,a}.
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    // All segments dark, and the dash (segment g only) used for nibbles A-F
    localparam seg_t SEG_OFF  = 7'h7F;
    localparam seg_t SEG_DASH = 7'h3F;

    // Decimal digit patterns, active-low
    localparam seg_t SEG_0 = 7'h40;
    localparam seg_t SEG_1 = 7'h79;
    localparam seg_t SEG_2 = 7'h24;
    localparam seg_t SEG_3 = 7'h30;
    localparam seg_t SEG_4 = 7'h19;
    localparam seg_t SEG_5 = 7'h12;
    localparam seg_t SEG_6 = 7'h02;
    localparam seg_t SEG_7 = 7'h78;
    localparam seg_t SEG_8 = 7'h00;
    localparam seg_t SEG_9 = 7'h10;

endpackage
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_7seg
//  Description : Combinational BCD nibble to active-low 7-segment decoder.
//                Non-decimal nibbles render as a dash.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);

    // Table lookup; A-F fall through to the dash pattern
    always_comb begin
        o_seg = SEG_DASH;
        case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_driver
//  Description : Time-multiplexes a 6-digit packed BCD value with decimal
//                points onto a common-anode display (active-low anodes and
//                segments). Input is snapshotted once per frame, leading
//                zeros may be blanked, and every digit change is preceded by
//                an all-anodes-off guard interval.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 100_000_000,
    parameter int DIGIT_RATE_HZ = 6_000,
    parameter int GUARD_CYCLES  = 4,
    parameter int NUM_DIGITS    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] bcd_data_in,
    input  logic [5:0]  dp_in,
    input  logic        blank_en,
    output logic [5:0]  an_out,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic        frame_tick
);

    localparam int TICK_DIV = CLK_FREQ_HZ / DIGIT_RATE_HZ;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW       = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GUARD_MAX = GW'(GUARD_CYCLES);
    localparam logic [2:0]    IDX_LAST  = 3'd5;

    // Reject configurations the scan timing cannot honour
    generate
        if (NUM_DIGITS != 6) begin : g_bad_num_digits
            $error("seven_seg_scan_driver: NUM_DIGITS must be 6");
        end
        if (TICK_DIV < GUARD_CYCLES + 2) begin : g_bad_tick_div
            $error("seven_seg_scan_driver: TICK_DIV must be at least GUARD_CYCLES+2");
        end
    endgenerate

    logic [PW-1:0] r_prescale;
    logic [2:0]    r_idx;
    logic [GW-1:0] r_guard;
    logic [23:0]   r_snap_bcd;
    logic [5:0]    r_snap_dp;
    logic          r_frame_tick;
    logic [5:0]    r_an;
    seg_t          r_seg;
    logic          r_dp;

    logic          w_tick;
    logic          w_frame_end;
    logic          w_guard_done;
    logic [5:0]    w_blankable;
    logic [5:0]    w_onehot;
    logic [3:0]    w_nibble;
    logic          w_dp_req;
    logic          w_blank_sel;
    logic          w_digit_on;
    seg_t          w_seg_dec;
    logic [5:0]    w_an_next;
    seg_t          w_seg_next;
    logic          w_dp_next;

    assign w_tick       = (r_prescale == TICK_LAST);
    assign w_frame_end  = w_tick && (r_idx == IDX_LAST);
    assign w_guard_done = (r_guard == GUARD_MAX);

    // Prescaler wraps every TICK_DIV clocks; digit index follows on each tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale <= '0;
            r_idx      <= 3'd0;
        end else if (w_tick) begin
            r_prescale <= '0;
            r_idx      <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_prescale <= r_prescale + PW'(1);
        end
    end

    // Guard counter restarts at each digit change and saturates when done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_guard <= '0;
        end else if (w_tick) begin
            r_guard <= '0;
        end else if (!w_guard_done) begin
            r_guard <= r_guard + GW'(1);
        end
    end

    // Capture the display value only at the frame boundary to avoid tearing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_bcd   <= '0;
            r_snap_dp    <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;
            if (w_frame_end) begin
                r_snap_bcd <= bcd_data_in;
                r_snap_dp  <= dp_in;
            end
        end
    end

    // A digit is a leading zero when it and every more-significant digit are 0
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign w_blankable[gi] = 1'b0;
            end else begin : g_upper
                assign w_blankable[gi] = ~|r_snap_bcd[23:4*gi];
            end
        end
    endgenerate

    // Select the nibble, decimal point and blanking state of the current digit
    always_comb begin
        w_nibble    = 4'h0;
        w_dp_req    = 1'b0;
        w_blank_sel = 1'b1;
        w_onehot    = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            if (r_idx == 3'(i)) begin
                w_nibble    = r_snap_bcd[4*i +: 4];
                w_dp_req    = r_snap_dp[i];
                w_blank_sel = blank_en && w_blankable[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    bcd_to_7seg u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

    // Segments and decimal point are forced dark whenever no anode is driven
    always_comb begin
        w_digit_on = w_guard_done && !w_blank_sel;
        w_an_next  = 6'h3F;
        w_seg_next = SEG_OFF;
        w_dp_next  = 1'b1;
        if (w_digit_on) begin
            w_an_next  = ~w_onehot;
            w_seg_next = w_seg_dec;
            w_dp_next  = ~w_dp_req;
        end
    end

    // Register the pad outputs so they change cleanly, one cycle after state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= 6'h3F;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign an_out     = r_an;
    assign seg_out    = r_seg;
    assign dp_out     = r_dp;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scan_driver
//  Description : Scoreboard bench for the 6-digit scan driver. Stimulus pushes
//                the hand-computed lit slots of each frame; a monitor pops one
//                entry per lit digit slot and checks anode, segments, dp,
//                guard length, slot length and frame period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] bcd_data_in;
    logic [5:0]  dp_in;
    logic        blank_en;
    logic [5:0]  an_out;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic        frame_tick;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        int         guard;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .CLK_FREQ_HZ   (1000),
        .DIGIT_RATE_HZ (100),
        .GUARD_CYCLES  (2),
        .NUM_DIGITS    (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bcd_data_in (bcd_data_in),
        .dp_in       (dp_in),
        .blank_en    (blank_en),
        .an_out      (an_out),
        .seg_out     (seg_out),
        .dp_out      (dp_out),
        .frame_tick  (frame_tick)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // lit: digits expected to light; segs: {s5,...,s0}; dpl: active-low dp per digit
    task automatic push_row(input logic [5:0] lit, input logic [41:0] segs, input logic [5:0] dpl);
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            if (lit[i]) begin
                e.an    = 6'h3F;
                e.an[i] = 1'b0;
                e.seg   = segs[7*i +: 7];
                e.dp    = dpl[i];
                e.guard = (i > 0 && lit[i-1]) ? 2 : 0;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_ft();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 200);
        check("frame_tick_seen", int'(frame_tick), 1);
        check("scoreboard_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"},  int'(an_out),     'h3F);
        check({tag, "_seg"}, int'(seg_out),    'h7F);
        check({tag, "_dp"},  int'(dp_out),     1);
        check({tag, "_ft"},  int'(frame_tick), 0);
    endtask

    // Reset seen on a rising edge invalidates the frame-period measurement
    logic seen_rst = 1'b0;
    always @(posedge clk) if (rst) seen_rst = 1'b1;

    logic [5:0] prev_an   = 6'h3F;
    int         off_cnt   = 0;
    int         act_len   = 0;
    logic       off_bad   = 1'b0;
    logic       len_chk   = 1'b0;
    int         ft_cnt    = 0;
    logic       ft_valid  = 1'b0;

    // Monitor: one scoreboard pop per lit slot, plus timing checks
    always @(negedge clk) begin
        exp_t e;
        if (seen_rst) begin
            seen_rst = 1'b0;
            ft_valid = 1'b0;
            ft_cnt   = 0;
        end else begin
            ft_cnt++;
            if (frame_tick === 1'b1) begin
                if (ft_valid) check("frame_period", ft_cnt, 60);
                ft_valid = 1'b1;
                ft_cnt   = 0;
            end
        end

        if (an_out !== prev_an) begin
            if (prev_an != 6'h3F && len_chk) check("slot_len", act_len, 8);
            len_chk = 1'b0;
            if (an_out != 6'h3F) begin
                if (sb.size() == 0) begin
                    check("unexpected_slot_an", int'(an_out), 'h3F);
                end else begin
                    e = sb.pop_front();
                    check("slot_an",  int'(an_out),  int'(e.an));
                    check("slot_seg", int'(seg_out), int'(e.seg));
                    check("slot_dp",  int'(dp_out),  int'(e.dp));
                    if (e.guard != 0) check("guard_len", off_cnt, e.guard);
                    check("guard_dark", int'(off_bad), 0);
                    len_chk = 1'b1;
                end
                act_len = 0;
            end
            off_cnt = 0;
            off_bad = 1'b0;
        end

        if (an_out == 6'h3F) begin
            off_cnt++;
            if (seg_out !== 7'h7F || dp_out !== 1'b1) off_bad = 1'b1;
        end else begin
            act_len++;
        end
        prev_an = an_out;
    end

    // Stimulus: at each frame_tick push the frame now starting, then set the
    // inputs for the next snapshot. blank_en is live so it changes per frame.
    initial begin
        rst         = 1'b1;
        bcd_data_in = 24'h0;
        dp_in       = 6'h0;
        blank_en    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // First frame after reset shows the zero snapshot
        push_row(6'h3F, {6{7'h40}}, 6'h3F);
        bcd_data_in = 24'h012345;
        dp_in       = 6'b000100;

        wait_ft();
        push_row(6'h3F, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, 6'b111011);
        bcd_data_in = 24'h000305;
        dp_in       = 6'b000000;

        // Digits 3-5 are leading zeros; the inner zero at digit 1 stays lit
        wait_ft();
        blank_en = 1'b1;
        push_row(6'b000111, {7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h12}, 6'h3F);
        bcd_data_in = 24'h000000;

        wait_ft();
        push_row(6'b000001, {6{7'h40}}, 6'h3F);
        bcd_data_in = 24'h111111;

        // Mid-frame change (digit index 2) must not reach this frame
        wait_ft();
        blank_en = 1'b0;
        push_row(6'h3F, {6{7'h79}}, 6'h3F);
        repeat (25) @(negedge clk);
        bcd_data_in = 24'h222222;

        wait_ft();
        push_row(6'h3F, {6{7'h24}}, 6'h3F);
        bcd_data_in = 24'h0000A0;

        wait_ft();
        push_row(6'h3F, {7'h40, 7'h40, 7'h40, 7'h40, 7'h3F, 7'h40}, 6'h3F);
        bcd_data_in = 24'h987654;
        dp_in       = 6'b000001;

        // Digits 0-2 show, then reset lands while digit index is 3
        wait_ft();
        push_row(6'b000111, {7'h7F, 7'h7F, 7'h7F, 7'h02, 7'h12, 7'h19}, 6'b111110);
        repeat (31) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        push_row(6'h3F, {6{7'h40}}, 6'h3F);

        wait_ft();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
